// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// datapath mux/op encodings and the bundled control-word type.
package rv32i_ctrl_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       halted;
  } ctrl_t;

  // SYSTEM and anything outside the supported RV32I subset halt the core.
  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_LUI,
      OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the controller and memory.
interface rv32i_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/rv32i_multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags when the limit is reached.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority so a completed access or state change restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

  assign timeout = (cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath sharing one memory port.
//  state  | meaning
//  FETCH  | read instruction at PC, latch into IR on mem_ready
//  DECODE | precompute PC+imm, screen opcode
//  EXEC   | ALU operation; branches resolve and retire here
//  MEM    | load/store access at ALU address
//  WB     | register write-back and PC update
//  HALT   | parked until reset (illegal/SYSTEM opcode or bus timeout)
module rv32i_multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    start,
  input  logic [6:0]              opcode,
  input  logic                    br_taken,
  rv32i_multicycle_ctrl_if.master bus,
  output logic                    addr_sel,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic [1:0]              pc_src,
  output logic [1:0]              alu_a_sel,
  output logic                    alu_b_sel,
  output logic [1:0]              alu_op,
  output logic                    reg_we,
  output logic [1:0]              wb_sel,
  output logic                    retire,
  output logic                    halted,
  output logic                    bus_err,
  output logic [2:0]              state
);

  logic [2:0] state_q, state_d;
  logic       bus_err_q;
  logic       wait_state, timeout, bus_err_set;
  ctrl_t      c;

  assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign bus_err_set = wait_state && timeout && !bus.mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (start),
    .clr     (!wait_state || bus.mem_ready || timeout),
    .inc     (wait_state && !bus.mem_ready),
    .timeout (timeout)
  );

  // State register and sticky bus-error flag.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q   <= S_FETCH;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus_err_set) bus_err_q <= 1'b1;
    end
  end

  // Next-state and per-state control word decode.
  always_comb begin
    c       = '0;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        c.mem_req  = 1'b1;
        c.addr_sel = 1'b0;
        if (bus.mem_ready) begin
          c.ir_we = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) state_d = S_HALT;
        else                  state_d = S_FETCH;
      end
      S_DECODE: begin
        c.alu_a_sel = A_PC;
        c.alu_b_sel = B_IMM;
        state_d     = opcode_supported(opcode) ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (opcode)
          OP_OP:  begin c.alu_a_sel = A_RS1; c.alu_b_sel = B_RS2; c.alu_op = ALU_FUNCT; end
          OP_IMM: begin c.alu_a_sel = A_RS1; c.alu_b_sel = B_IMM; c.alu_op = ALU_FUNCT; end
          OP_LOAD, OP_STORE: begin
            c.alu_a_sel = A_RS1; c.alu_b_sel = B_IMM; c.alu_op = ALU_ADD;
            state_d     = S_MEM;
          end
          OP_LUI:   begin c.alu_a_sel = A_ZERO; c.alu_b_sel = B_IMM; end
          OP_AUIPC: begin c.alu_a_sel = A_PC;   c.alu_b_sel = B_IMM; end
          OP_JAL, OP_JALR: c.alu_op = ALU_ADD;
          OP_BRANCH: begin
            c.alu_a_sel = A_RS1; c.alu_b_sel = B_RS2; c.alu_op = ALU_CMP;
            c.pc_we     = 1'b1;
            c.pc_src    = br_taken ? PC_IMM : PC_PLUS4;
            c.retire    = 1'b1;
            state_d     = S_FETCH;
          end
          // IR is stable from DECODE, so this only guards against a corrupted opcode.
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        c.mem_req  = 1'b1;
        c.addr_sel = 1'b1;
        c.mem_we   = (opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (opcode == OP_STORE) begin
            c.pc_we  = 1'b1;
            c.pc_src = PC_PLUS4;
            c.retire = 1'b1;
            state_d  = S_FETCH;
          end else state_d = S_WB;
        end else if (timeout) state_d = S_HALT;
        else                  state_d = S_MEM;
      end
      S_WB: begin
        c.reg_we = 1'b1;
        c.pc_we  = 1'b1;
        c.retire = 1'b1;
        case (opcode)
          OP_LOAD:          c.wb_sel = WB_LOAD;
          OP_JAL, OP_JALR:  c.wb_sel = WB_PC4;
          default:          c.wb_sel = WB_ALU;
        endcase
        case (opcode)
          OP_JAL:  c.pc_src = PC_IMM;
          OP_JALR: c.pc_src = PC_JALR;
          default: c.pc_src = PC_PLUS4;
        endcase
        state_d = S_FETCH;
      end
      S_HALT: begin
        c.halted = 1'b1;
        state_d  = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low combinationally so nothing leaks while start is low.
  assign bus.mem_req = c.mem_req & start;
  assign bus.mem_we  = c.mem_we  & start;
  assign ir_we       = c.ir_we   & start;
  assign pc_we       = c.pc_we   & start;
  assign reg_we      = c.reg_we  & start;
  assign retire      = c.retire  & start;
  assign addr_sel    = c.addr_sel;
  assign pc_src      = c.pc_src;
  assign alu_a_sel   = c.alu_a_sel;
  assign alu_b_sel   = c.alu_b_sel;
  assign alu_op      = c.alu_op;
  assign wb_sel      = c.wb_sel;
  assign halted      = c.halted;
  assign bus_err     = bus_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for the multicycle RV32I control FSM.
module tb_rv32i_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       start;
  logic [6:0] opcode;
  logic       br_taken;
  logic       addr_sel, ir_we, pc_we, reg_we, retire, halted, bus_err, alu_b_sel;
  logic [1:0] pc_src, alu_a_sel, alu_op, wb_sel;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  rv32i_multicycle_ctrl_if bus ();

  rv32i_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk       (clk),
    .start     (start),
    .opcode    (opcode),
    .br_taken  (br_taken),
    .bus       (bus),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .retire    (retire),
    .halted    (halted),
    .bus_err   (bus_err),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: pulse reset low across a clock edge, release on a negedge.
  task automatic do_reset();
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b0; opcode = 7'b0110011; br_taken = 1'b0; bus.mem_ready = 1'b1;
    #12;
    checks++;
    if ({state, bus.mem_req, ir_we, pc_we, reg_we, retire, halted, bus_err} !== 10'b000_0000000) begin
      errors++;
      $display("FAIL reset_outputs: got st=%0d req=%b ir=%b pc=%b rw=%b ret=%b h=%b be=%b, expected 0",
               state, bus.mem_req, ir_we, pc_we, reg_we, retire, halted, bus_err);
    end
    @(negedge clk);
    start = 1'b1;
    #1;
    checks++;
    if ({state, bus.mem_req, addr_sel, ir_we} !== 6'b000_101) begin
      errors++;
      $display("FAIL reset_release_fetch: got st=%0d req=%b as=%b ir=%b, expected st=0 req=1 as=0 ir=1",
               state, bus.mem_req, addr_sel, ir_we);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_rtype();
    logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    opcode = 7'b0110011; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== exp_st[i]) begin
        errors++;
        $display("FAIL rtype_state cyc%0d: got %0d expected %0d", i, state, exp_st[i]);
      end
      checks++;
      if ({reg_we, pc_we, retire} !== ((i == 3) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL rtype_strobes cyc%0d: got rw/pc/ret=%b%b%b", i, reg_we, pc_we, retire);
      end
      if (i == 2) begin
        checks++;
        if ({alu_a_sel, alu_b_sel, alu_op} !== 5'b00_0_10) begin
          errors++;
          $display("FAIL rtype_exec_alu: got a=%0d b=%0d op=%0d expected 0 0 2", alu_a_sel, alu_b_sel, alu_op);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL rtype_end: got %0d expected 0", state); end
  endtask

  task automatic test_load_wait();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    logic       rdy    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 7'b0000011;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (state !== exp_st[i]) begin
        errors++;
        $display("FAIL load_state cyc%0d: got %0d expected %0d", i, state, exp_st[i]);
      end
      if (i >= 3 && i <= 6) begin
        checks++;
        if ({bus.mem_req, addr_sel, bus.mem_we, reg_we} !== 4'b1100) begin
          errors++;
          $display("FAIL load_mem cyc%0d: got req=%b as=%b we=%b rw=%b", i, bus.mem_req, addr_sel, bus.mem_we, reg_we);
        end
      end
      if (i == 7) begin
        checks++;
        if ({reg_we, wb_sel, pc_we, pc_src, retire} !== 7'b1_01_1_00_1) begin
          errors++;
          $display("FAIL load_wb: got rw=%b wb=%0d pc=%b src=%0d ret=%b", reg_we, wb_sel, pc_we, pc_src, retire);
        end
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL load_end: got %0d expected 0", state); end
  endtask

  task automatic test_branch(input logic taken);
    opcode = 7'b1100011; br_taken = taken; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL branch_fetch: got %0d expected 0", state); end
    @(negedge clk); #1;
    checks++;
    if ({state, pc_we, retire} !== 5'b001_00) begin
      errors++;
      $display("FAIL branch_decode: got st=%0d pc=%b ret=%b", state, pc_we, retire);
    end
    @(negedge clk); #1;
    checks++;
    if ({state, pc_we, pc_src, retire, alu_op, reg_we} !== {3'd2, 1'b1, (taken ? 2'd1 : 2'd0), 1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL branch_exec taken=%b: got st=%0d pc=%b src=%0d ret=%b op=%0d rw=%b",
               taken, state, pc_we, pc_src, retire, alu_op, reg_we);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL branch_end taken=%b: got %0d expected 0", taken, state); end
    br_taken = 1'b0;
  endtask

  task automatic test_jalr();
    opcode = 7'b1100111; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({state, pc_src, wb_sel, reg_we, pc_we, retire} !== {3'd4, 2'd2, 2'd2, 3'b111}) begin
      errors++;
      $display("FAIL jalr_wb: got st=%0d src=%0d wb=%0d rw=%b pc=%b ret=%b", state, pc_src, wb_sel, reg_we, pc_we, retire);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL jalr_end: got %0d expected 0", state); end
  endtask

  task automatic test_store();
    opcode = 7'b0100011; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({state, bus.mem_req, bus.mem_we, addr_sel, reg_we, pc_we, pc_src, retire} !== {3'd3, 4'b1110, 1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL store_mem: got st=%0d req=%b we=%b as=%b rw=%b pc=%b src=%0d ret=%b",
               state, bus.mem_req, bus.mem_we, addr_sel, reg_we, pc_we, pc_src, retire);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL store_end: got %0d expected 0 (4 cycles)", state); end
  endtask

  task automatic test_system_halt();
    opcode = 7'b1110011; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({state, halted, bus_err, bus.mem_req, pc_we, reg_we} !== {3'd5, 5'b10000}) begin
      errors++;
      $display("FAIL system_halt: got st=%0d h=%b be=%b req=%b pc=%b rw=%b", state, halted, bus_err, bus.mem_req, pc_we, reg_we);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state !== 3'd5) begin errors++; $display("FAIL system_stays_halted: got %0d expected 5", state); end
    do_reset();
    #1;
    checks++;
    if ({state, halted} !== 4'b000_0) begin errors++; $display("FAIL system_reset_exit: got st=%0d h=%b", state, halted); end
  endtask

  task automatic test_timeout();
    bus.mem_ready = 1'b0; opcode = 7'b0110011;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (state !== 3'd0) begin
        errors++;
        $display("FAIL timeout_wait cyc%0d: got st=%0d expected 0", i, state);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({state, halted, bus_err, bus.mem_req} !== {3'd5, 3'b110}) begin
      errors++;
      $display("FAIL timeout_halt: got st=%0d h=%b be=%b req=%b expected st=5 h=1 be=1 req=0", state, halted, bus_err, bus.mem_req);
    end
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({state, bus_err} !== {3'd5, 1'b1}) begin
      errors++;
      $display("FAIL timeout_sticky: got st=%0d be=%b", state, bus_err);
    end
    do_reset();
    #1;
    checks++;
    if ({state, bus_err, halted} !== 5'b000_00) begin
      errors++;
      $display("FAIL timeout_reset_clear: got st=%0d be=%b h=%b", state, bus_err, halted);
    end
  endtask

  task automatic test_ready_wins();
    bus.mem_ready = 1'b0; opcode = 7'b0110011;
    repeat (15) @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, ir_we} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL ready_wins_fetch: got st=%0d ir=%b expected st=0 ir=1", state, ir_we);
    end
    @(negedge clk); #1;
    checks++;
    if ({state, bus_err, halted} !== {3'd1, 2'b00}) begin
      errors++;
      $display("FAIL ready_wins_decode: got st=%0d be=%b h=%b expected st=1 be=0 h=0", state, bus_err, halted);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL ready_wins_end: got %0d expected 0", state); end
  endtask

  task automatic test_reset_mid_mem();
    opcode = 7'b0000011; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if ({state, bus.mem_req} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL midmem_in_mem: got st=%0d req=%b", state, bus.mem_req);
    end
    #2 start = 1'b0;
    #1;
    checks++;
    if ({state, bus.mem_req, pc_we, reg_we, retire, ir_we} !== 8'b000_00000) begin
      errors++;
      $display("FAIL midmem_abort: got st=%0d req=%b pc=%b rw=%b ret=%b ir=%b",
               state, bus.mem_req, pc_we, reg_we, retire, ir_we);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({state, bus.mem_req, ir_we} !== 5'b000_00) begin
      errors++;
      $display("FAIL midmem_held: got st=%0d req=%b ir=%b", state, bus.mem_req, ir_we);
    end
    start = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jalr();
    test_store();
    test_system_halt();
    test_timeout();
    test_ready_wins();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
